// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage, one transaction in flight.
// Optional fetch anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    input  logic                    if_flush,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    dm_req_valid,
    input  logic                    dm_req_we,
    input  logic [ADDR_WIDTH-1:0]   dm_req_addr,
    input  logic [DATA_WIDTH-1:0]   dm_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_req_wstrb,
    output logic                    dm_req_ready,
    output logic                    dm_rsp_valid,
    output logic [DATA_WIDTH-1:0]   dm_rsp_data,
    output logic                    mem_req_valid,
    output logic                    mem_req_we,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
    input  logic                    mem_req_ready,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t state;
    logic   owner_fetch;
    logic   drop;
    logic   fetch_ok;
    logic   force_fetch;
    logic   grant_if;
    logic   grant_dm;

    // Data wins by default; a forced fetch grant only happens when fetch can actually be taken.
    always_comb begin
        fetch_ok = if_req_valid && !if_flush;
        grant_if = (state == IDLE) && fetch_ok && (!dm_req_valid || force_fetch);
        grant_dm = (state == IDLE) && dm_req_valid && !grant_if;
    end

    assign if_req_ready = grant_if;
    assign dm_req_ready = grant_dm;
    assign busy         = (state != IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] wait_cnt;

    assign force_fetch = (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (grant_if || (state == IDLE && !if_req_valid)) begin
            wait_cnt <= 4'd0;
        end else if (grant_dm && fetch_ok) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    // Strict data priority: a legal limit is never zero, so fetch is never forced.
    assign force_fetch = (WAIT_LIMIT == 4'd0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner_fetch   <= 1'b0;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            dm_rsp_valid  <= 1'b0;
            dm_rsp_data   <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_if || grant_dm) begin
                        state         <= ISSUE;
                        mem_req_valid <= 1'b1;
                        owner_fetch   <= grant_if;
                        mem_req_we    <= grant_dm && dm_req_we;
                        mem_req_addr  <= grant_if ? if_req_addr : dm_req_addr;
                        mem_req_wdata <= grant_if ? '0 : dm_req_wdata;
                        mem_req_wstrb <= grant_if ? '0 : dm_req_wstrb;
                    end
                end
                ISSUE: begin
                    if (owner_fetch && if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (owner_fetch && if_flush) begin
                        drop <= 1'b1;
                    end
                    // A flush on the very cycle the response lands still drops it.
                    if (mem_rsp_valid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        if (owner_fetch) begin
                            if (!(drop || if_flush)) begin
                                if_rsp_valid <= 1'b1;
                                if_rsp_data  <= mem_rsp_data;
                            end
                        end else begin
                            dm_rsp_valid <= 1'b1;
                            dm_rsp_data  <= mem_req_we ? '0 : mem_rsp_data;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vector table plus hand-written corner sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_wstrb;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        busy;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb), .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ifv;
        logic [31:0] ifa;
        logic        flush;
        logic        dmv;
        logic        dmwe;
        logic [31:0] dma;
        logic [31:0] dmwd;
        logic [3:0]  dmws;
        logic        mrdy;
        logic        mrspv;
        logic [31:0] mrspd;
        logic        e_ifrdy;
        logic        e_dmrdy;
        logic        e_mrv;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic [3:0]  e_mws;
        logic        e_ifrv;
        logic [31:0] e_ifd;
        logic        e_dmrv;
        logic [31:0] e_dmd;
        logic        e_busy;
    } vec_t;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    vec_t vecs[23];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req_valid  = v.ifv;
        if_req_addr   = v.ifa;
        if_flush      = v.flush;
        dm_req_valid  = v.dmv;
        dm_req_we     = v.dmwe;
        dm_req_addr   = v.dma;
        dm_req_wdata  = v.dmwd;
        dm_req_wstrb  = v.dmws;
        mem_req_ready = v.mrdy;
        mem_rsp_valid = v.mrspv;
        mem_rsp_data  = v.mrspd;
    endtask

    task automatic idleInputs();
        vec_t z;
        z = '{"idle", L, 32'h0, L, L, L, 32'h0, 32'h0, 4'h0, L, L, 32'h0,
              L, L, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0, L, 32'h0, L};
        applyStimulus(z);
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".if_req_ready"},  32'(if_req_ready),  32'(v.e_ifrdy));
        checkOutput({v.name, ".dm_req_ready"},  32'(dm_req_ready),  32'(v.e_dmrdy));
        checkOutput({v.name, ".mem_req_valid"}, 32'(mem_req_valid), 32'(v.e_mrv));
        checkOutput({v.name, ".mem_req_we"},    32'(mem_req_we),    32'(v.e_mwe));
        checkOutput({v.name, ".mem_req_addr"},  mem_req_addr,       v.e_maddr);
        checkOutput({v.name, ".mem_req_wdata"}, mem_req_wdata,      v.e_mwd);
        checkOutput({v.name, ".mem_req_wstrb"}, 32'(mem_req_wstrb), 32'(v.e_mws));
        checkOutput({v.name, ".if_rsp_valid"},  32'(if_rsp_valid),  32'(v.e_ifrv));
        checkOutput({v.name, ".if_rsp_data"},   if_rsp_data,        v.e_ifd);
        checkOutput({v.name, ".dm_rsp_valid"},  32'(dm_rsp_valid),  32'(v.e_dmrv));
        checkOutput({v.name, ".dm_rsp_data"},   dm_rsp_data,        v.e_dmd);
        checkOutput({v.name, ".busy"},          32'(busy),          32'(v.e_busy));
    endtask

    initial begin
        int pulses;
        logic [1:0] exp_grant;

        //            name           ifv ifa           fl dmv we dma          dmwd          ws    rdy rsp rspd
        //                           irdy drdy mrv mwe maddr     mwd           mws   ifrv ifd           dmrv dmd           busy
        vecs[0]  = '{"idle",         L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h0,    32'h0,        4'h0, L, 32'h0,        L, 32'h0,        L};
        vecs[1]  = '{"fetch_req",    H, 32'h100,   L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     H, L, L, L, 32'h0,    32'h0,        4'h0, L, 32'h0,        L, 32'h0,        L};
        vecs[2]  = '{"fetch_issue",  L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, H, L, 32'h0,
                                     L, L, H, L, 32'h100,  32'h0,        4'h0, L, 32'h0,        L, 32'h0,        H};
        vecs[3]  = '{"fetch_wait",   L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, H, 32'h00500093,
                                     L, L, L, L, 32'h100,  32'h0,        4'h0, L, 32'h0,        L, 32'h0,        H};
        vecs[4]  = '{"fetch_rsp",    L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h100,  32'h0,        4'h0, H, 32'h00500093, L, 32'h0,        L};
        vecs[5]  = '{"fetch_after",  L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h100,  32'h0,        4'h0, L, 32'h00500093, L, 32'h0,        L};
        vecs[6]  = '{"cont_grant",   H, 32'h200,   L, H, H, 32'h2000, 32'hCAFEF00D, 4'hF, L, L, 32'h0,
                                     L, H, L, L, 32'h100,  32'h0,        4'h0, L, 32'h00500093, L, 32'h0,        L};
        vecs[7]  = '{"cont_issue",   H, 32'h200,   L, L, L, 32'h0,    32'h0,        4'h0, H, L, 32'h0,
                                     L, L, H, H, 32'h2000, 32'hCAFEF00D, 4'hF, L, 32'h00500093, L, 32'h0,        H};
        vecs[8]  = '{"cont_wait",    H, 32'h200,   L, L, L, 32'h0,    32'h0,        4'h0, L, H, 32'h12345678,
                                     L, L, L, H, 32'h2000, 32'hCAFEF00D, 4'hF, L, 32'h00500093, L, 32'h0,        H};
        vecs[9]  = '{"cont_rsp",     H, 32'h200,   L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     H, L, L, H, 32'h2000, 32'hCAFEF00D, 4'hF, L, 32'h00500093, H, 32'h0,        L};
        vecs[10] = '{"cont_fissue",  L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, H, L, 32'h0,
                                     L, L, H, L, 32'h200,  32'h0,        4'h0, L, 32'h00500093, L, 32'h0,        H};
        vecs[11] = '{"cont_fwait",   L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, H, 32'h00000013,
                                     L, L, L, L, 32'h200,  32'h0,        4'h0, L, 32'h00500093, L, 32'h0,        H};
        vecs[12] = '{"cont_frsp",    L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h200,  32'h0,        4'h0, H, 32'h00000013, L, 32'h0,        L};
        vecs[13] = '{"flush_req",    H, 32'h300,   L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     H, L, L, L, 32'h200,  32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        L};
        vecs[14] = '{"flush_issue",  L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, H, L, 32'h0,
                                     L, L, H, L, 32'h300,  32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        H};
        vecs[15] = '{"flush_pulse",  L, 32'h0,     H, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h300,  32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        H};
        vecs[16] = '{"flush_rsp",    L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, H, 32'hDEADBEEF,
                                     L, L, L, L, 32'h300,  32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        H};
        vecs[17] = '{"flush_after",  L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h300,  32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        L};
        vecs[18] = '{"flush_block",  H, 32'h400,   H, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h300,  32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        L};
        vecs[19] = '{"load_req",     L, 32'h0,     L, H, L, 32'h44,   32'h0,        4'h0, L, L, 32'h0,
                                     L, H, L, L, 32'h300,  32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        L};
        vecs[20] = '{"load_issue",   L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, H, L, 32'h0,
                                     L, L, H, L, 32'h44,   32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        H};
        vecs[21] = '{"load_wait",    L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, H, 32'hAABBCCDD,
                                     L, L, L, L, 32'h44,   32'h0,        4'h0, L, 32'h00000013, L, 32'h0,        H};
        vecs[22] = '{"load_rsp",     L, 32'h0,     L, L, L, 32'h0,    32'h0,        4'h0, L, L, 32'h0,
                                     L, L, L, L, 32'h44,   32'h0,        4'h0, L, 32'h00000013, H, 32'hAABBCCDD, L};

        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        checkVector(vecs[0]);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkVector(vecs[i]);
        end

        // Backpressure: request fields must hold while memory stalls, one response only.
        $display("[TB] backpressure sequence");
        pulses = 0;
        @(negedge clk);
        idleInputs();
        dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h3000;
        dm_req_wdata = 32'h55AA55AA; dm_req_wstrb = 4'h3;
        #1;
        checkOutput("bp_grant", 32'(dm_req_ready), 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idleInputs();
            dm_req_wdata = 32'hFFFFFFFF;
            #1;
            checkOutput("bp_stall.valid", 32'(mem_req_valid), 32'h1);
            checkOutput("bp_stall.addr",  mem_req_addr,       32'h3000);
            checkOutput("bp_stall.wdata", mem_req_wdata,      32'h55AA55AA);
            checkOutput("bp_stall.wstrb", 32'(mem_req_wstrb), 32'h3);
            checkOutput("bp_stall.we",    32'(mem_req_we),    32'h1);
            if (dm_rsp_valid) pulses++;
        end
        @(negedge clk);
        idleInputs();
        mem_req_ready = 1'b1;
        #1;
        checkOutput("bp_accept.valid", 32'(mem_req_valid), 32'h1);
        @(negedge clk);
        idleInputs();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BADF00D;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idleInputs();
            #1;
            if (dm_rsp_valid) begin
                pulses++;
                checkOutput("bp_rsp.data", dm_rsp_data, 32'h0);
            end
        end
        checkOutput("bp_rsp_count", 32'(pulses), 32'h1);

        // Both requesters held high: grant order depends on the guard build.
        $display("[TB] starvation sequence");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idleInputs();
            if_req_valid = 1'b1; if_req_addr = 32'h600;
            dm_req_valid = 1'b1; dm_req_addr = 32'h500;
            #1;
            exp_grant = (GUARD && (k % 3 == 2)) ? 2'b10 : 2'b01;
            checkOutput($sformatf("starve_grant_%0d", k), 32'({if_req_ready, dm_req_ready}), 32'(exp_grant));
            @(negedge clk);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'h11110000 + 32'(k);
        end
        @(negedge clk);
        idleInputs();

        // Reset landing between clock edges while a fetch sits in ISSUE.
        $display("[TB] async reset sequence");
        @(negedge clk);
        if_req_valid = 1'b1; if_req_addr = 32'h700;
        #1;
        checkOutput("rst_seq.grant", 32'(if_req_ready), 32'h1);
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("rst_seq.issue_valid", 32'(mem_req_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_seq.valid_drop", 32'(mem_req_valid), 32'h0);
        checkOutput("rst_seq.busy",       32'(busy),          32'h0);
        checkOutput("rst_seq.addr",       mem_req_addr,       32'h0);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h00000077;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (if_rsp_valid || dm_rsp_valid) pulses++;
            checkOutput("rst_seq.idle_busy", 32'(busy), 32'h0);
            @(negedge clk);
            idleInputs();
        end
        checkOutput("rst_seq.rsp_count", 32'(pulses), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
